// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - trigger link state encoding and default timing constants
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACKING = 2'd2,
    ST_HOLD   = 2'd3
  } trig_state_e;

  localparam int unsigned DEF_ACK_WIDTH = 4;
  localparam int unsigned DEF_HOLDOFF   = 16;
  localparam int unsigned DEF_CNT_W     = 16;

  // Down-counter must hold the 8-bit delay as well as either load constant.
  function automatic int cnt_width(input int unsigned ack_width, input int unsigned holdoff);
    int w;
    w = 8;
    if (int'($clog2(ack_width)) > w) w = int'($clog2(ack_width));
    if (int'($clog2(holdoff)) > w) w = int'($clog2(holdoff));
    return w;
  endfunction

endpackage

// File: rtl/trig_responder_sync_rise.sv
// rtl/trig_responder_sync_rise.sv - three-flop synchronizer with rising-edge detect
module sync_rise (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  // Reset to ones so a level already high at release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/trig_responder.sv
// rtl/trig_responder.sv - trigger endpoint: delayed fixed-width ACK, holdoff, event/missed counters
module trig_responder
  import trig_pkg::*;
#(
  parameter int unsigned ACK_WIDTH = DEF_ACK_WIDTH,
  parameter int unsigned HOLDOFF   = DEF_HOLDOFF,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             CLK_80MHZ,
  input  logic             RST,
  input  logic             TRG,
  input  logic             EN,
  input  logic [7:0]       ACK_DELAY,
  input  logic             CLR_COUNTS,
  output logic             ACK,
  output logic             BUSY,
  output logic [CNT_W-1:0] EVENT_COUNT,
  output logic [CNT_W-1:0] MISSED_COUNT
);

  localparam int CW = cnt_width(ACK_WIDTH, HOLDOFF);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_WIDTH - 1);
  localparam bit            NO_HOLD   = (HOLDOFF == 0);
  localparam logic [CW-1:0] HOLD_LOAD = NO_HOLD ? '0 : CW'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  trig_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;
  logic          accept;
  logic          miss;

  sync_rise u_sync (
    .clk    (CLK_80MHZ),
    .resetn (RST),
    .din    (TRG),
    .rise   (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    miss    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise && EN) begin
          accept = 1'b1;
          if (ACK_DELAY == 8'd0) begin
            state_d = ST_ACKING;
            cnt_d   = ACK_LOAD;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = CW'(ACK_DELAY - 8'd1);
          end
        end
      end
      ST_DELAY: begin
        miss = rise;
        if (cnt_q == '0) begin
          state_d = ST_ACKING;
          cnt_d   = ACK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ACKING: begin
        miss = rise;
        if (cnt_q == '0) begin
          if (NO_HOLD) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        miss = rise;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ACK and BUSY are registered from the next state so they line up with it.
  always_ff @(posedge CLK_80MHZ) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ACK     <= (state_d == ST_ACKING);
      BUSY    <= (state_d != ST_IDLE);
    end
  end

  // Clear wins over a same-cycle increment; missed count sticks at all-ones.
  always_ff @(posedge CLK_80MHZ) begin
    if (!RST || CLR_COUNTS) begin
      EVENT_COUNT  <= '0;
      MISSED_COUNT <= '0;
    end else begin
      if (accept) EVENT_COUNT <= EVENT_COUNT + STAT_ONE;
      if (miss && (MISSED_COUNT != '1)) MISSED_COUNT <= MISSED_COUNT + STAT_ONE;
    end
  end

endmodule

// File: doc/trig_responder.md
# trig_responder

- Endpoint (SCROD-side) of the trigger/acknowledge link driven by the crate trigger block.
- Receives one asynchronous `TRG` line and detects its rising edges.
- For each accepted trigger, waits a programmable delay and returns a fixed-width `ACK` pulse, then enforces a dead time.
- Counts accepted and missed triggers; used on front-end boards and as a loopback responder for crate-level trigger tests.

## Interface
Parameters:
- `ACK_WIDTH`, 4: `ACK` high time in clocks, ≥1.
- `HOLDOFF`, 16: dead time in clocks after `ACK` falls, ≥0.
- `CNT_W`, 16: width of the event and missed counters.

Ports:
- `CLK_80MHZ` in 1: sole clock.
- `RST` in 1: reset, synchronous, active-low.
- `TRG` in 1: trigger from crate, asynchronous.
- `EN` in 1: accept new triggers when high.
- `ACK_DELAY` in 8: clocks between detection and `ACK` rise.
- `CLR_COUNTS` in 1: synchronous clear of both counters.
- `ACK` out 1: acknowledge to crate, registered.
- `BUSY` out 1: high in any state other than IDLE, registered.
- `EVENT_COUNT` out `CNT_W`: accepted triggers; wraps.
- `MISSED_COUNT` out `CNT_W`: rejected rising edges; saturates at all-ones.

## Operation
- **Synchronizer:**
  - `TRG` passes through `s1` then `s2`; `s3` is `s2` delayed one clock.
  - `rise = s2 & ~s3`.
  - All three flops reset to 1, so a `TRG` held high or low through reset never produces a rise.
- **FSM states:** IDLE, DELAY, ACKING, HOLD.
  - IDLE: on `rise & EN`:
    - go to ACKING if `ACK_DELAY==0`;
    - otherwise load `cnt=ACK_DELAY-1` and go to DELAY;
    - increment `EVENT_COUNT` in either case.
  - DELAY: decrement `cnt`; at `cnt==0` go to ACKING with `cnt=ACK_WIDTH-1`.
  - ACKING: `ACK=1`; decrement; at 0 go to HOLD with `cnt=HOLDOFF-1`, or to IDLE if `HOLDOFF==0`.
  - HOLD: decrement; at 0 go to IDLE.
- **`ACK_DELAY` capture:** sampled only at acceptance; changes mid-sequence have no effect.
- **Rejected rises:**
  - a `rise` while not IDLE increments `MISSED_COUNT` (saturating);
  - a `rise` in IDLE with `EN=0` is ignored and not counted.
- **`EN` deasserted mid-sequence:** the current sequence completes normally.
- **`CLR_COUNTS`:** zeroes both counters next clock. It takes priority over a simultaneous increment, so that event is lost.
- **`RST` low at any clock edge:**
  - state→IDLE, `ACK=0`, `BUSY=0`, counters=0, `cnt=0`, `s1..s3=1`;
  - an in-flight `ACK` is truncated.
- **Reset values:** `ACK=0`, `BUSY=0`, `EVENT_COUNT=0`, `MISSED_COUNT=0`.

## Timing
- `TRG` first sampled high at edge 0. Then:
  - `rise` is valid after edge 1;
  - the FSM leaves IDLE at edge 2;
  - `BUSY` rises after edge 2;
  - `EVENT_COUNT` updates at edge 2.
- `ACK` rises after edge `2+ACK_DELAY` and stays high exactly `ACK_WIDTH` clocks.
- `BUSY` falls after edge `2+ACK_DELAY+ACK_WIDTH+HOLDOFF`.
- The earliest next acceptance is the rise detected in the cycle `BUSY` is low.
  - A rise whose detection cycle coincides with the HOLD→IDLE transition edge is counted as missed.
- **Minimum `TRG` pulse:** high for 2 clocks and low for 2 clocks to guarantee detection.
- `ACK`, `BUSY` and the counters are driven directly from flops (no combinational output paths).

## Structure
- **Package `trig_pkg`:**
  - FSM state enum (IDLE=0, DELAY=1, ACKING=2, HOLD=3);
  - default `ACK_WIDTH`, `HOLDOFF`, `CNT_W` constants;
  - shared with the crate trigger block for link timing constants.
- **Sub-module `sync_rise`:**
  - 3-flop synchronizer plus rise detect;
  - reset-to-1 behaviour as above;
  - output `rise`.
- **Top:** the FSM, the down-counter `cnt` (width = max of 8, clog2(`ACK_WIDTH`), clog2(`HOLDOFF`)) and the two statistics counters.

## Test plan
- **Single trigger:** defaults, `ACK_DELAY=5`, `TRG` high 3 clocks at edge 0 → `ACK` high edges 7–10 inclusive, `BUSY` low after edge 27, `EVENT_COUNT=1`, `MISSED_COUNT=0`.
- **Zero delay / zero holdoff:** `ACK_DELAY=0`, `HOLDOFF=0` → `ACK` rises after edge 2, `BUSY` falls after edge 6; a second `TRG` accepted right after gives `EVENT_COUNT=2`.
- **Triggers during busy:** 3 extra `TRG` pulses during DELAY/ACKING/HOLD → `MISSED_COUNT=3`, a single `ACK` pulse, `EVENT_COUNT=1`. With `CNT_W=4` and 20 missed edges → `MISSED_COUNT=15`.
- **`EN` and clear:**
  - `EN=0` with 4 pulses → no `ACK`, both counts 0;
  - `CLR_COUNTS` on the same edge as an acceptance → `EVENT_COUNT=0`, but the `ACK` pulse still occurs;
  - `EVENT_COUNT` at all-ones plus 1 accepted trigger → wraps to 0.
- **Reset mid-operation:** `RST` low during ACKING → `ACK=0` and `BUSY=0` next clock, counts 0. `TRG` held high through reset release → no `ACK`, `EVENT_COUNT=0`.
- **Delay capture:** `ACK_DELAY` changed from 10 to 2 during DELAY → `ACK` still rises after edge 12.
